// File: rtl/polirv_pkg.sv
// polirv_pkg: shared definitions for the polirv single-cycle RV64I-subset core.
// Holds the opcode, funct3 and funct7 encodings the decoder recognises, the
// ALU operation enum, and a small helper that evaluates one ALU operation.
// No ports (package).
package polirv_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 encodings (instruction bits [14:12])
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_DOUBLE  = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // funct7 encodings (instruction bits [31:25])
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  // Evaluates one ALU operation; all arithmetic wraps modulo 2^64.
  function automatic logic [63:0] aluCompute(input alu_op_e op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
    logic [63:0] result;
    case (op)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = a + b;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/polirv_regfile.sv
// polirv_regfile: 32 x 64-bit integer register file for polirv_core.
// Ports:
//   clk        rising-edge clock for writes and clear
//   rst_n      synchronous active-high clear of every register
//   i_raddr1/2 combinational read addresses, o_rdata1/2 read data
//   i_we       write enable, i_waddr/i_wdata write address and data
// Register x0 always reads as zero and silently ignores writes. Clear has
// priority over a write presented in the same cycle.
module polirv_regfile
  import polirv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [63:0] o_rdata1,
  output logic [63:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [63:0] i_wdata
);

  logic [63:0] r_regs [32];

  // Storage update: clear all registers on reset, otherwise accept one write
  // per cycle; writes aimed at x0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports are purely combinational so a value written at an edge is seen
  // by the instruction fetched right after that edge.
  always_comb begin
    o_rdata1 = (i_raddr1 == 5'd0) ? 64'd0 : r_regs[i_raddr1];
    o_rdata2 = (i_raddr2 == 5'd0) ? 64'd0 : r_regs[i_raddr2];
  end

endmodule

// File: rtl/polirv_core.sv
// polirv_core: single-cycle RV64I-subset core (ADD/SUB/AND/OR, ADDI, LD, SD,
// BEQ, BNE). Every other encoding retires as a NOP.
// Ports:
//   clk, rst_n   clock and synchronous active-high reset
//   i_mem_addr   instruction word address (PC[7:2]); i_mem_data instruction
//   d_mem_we/re  data memory write/read strobes (never both high)
//   d_mem_addr   data doubleword address (effective address [8:3])
//   d_mem_data   shared bidirectional data bus; driven here only during stores
module polirv_core
  import polirv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          IADDR_W  = 6,
  parameter int          DADDR_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IADDR_W-1:0] i_mem_addr,
  input  logic [31:0]        i_mem_data,
  output logic               d_mem_we,
  output logic               d_mem_re,
  output logic [DADDR_W-1:0] d_mem_addr,
  inout  wire  [63:0]        d_mem_data
);

  logic [63:0] r_pc;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic [63:0] w_immI;
  logic [63:0] w_immS;
  logic [63:0] w_immB;
  logic [63:0] w_rs1Data;
  logic [63:0] w_rs2Data;
  logic [63:0] w_opB;
  logic [63:0] w_aluResult;
  logic [63:0] w_wbData;
  logic [63:0] w_nextPc;
  alu_op_e     w_aluOp;
  logic        w_regWe;
  logic        w_isLoad;
  logic        w_isStore;
  logic        w_branchTaken;

  assign w_opcode = i_mem_data[6:0];
  assign w_rd     = i_mem_data[11:7];
  assign w_funct3 = i_mem_data[14:12];
  assign w_rs1    = i_mem_data[19:15];
  assign w_rs2    = i_mem_data[24:20];
  assign w_funct7 = i_mem_data[31:25];

  // Sign-extended immediates; the branch offset is halfword-scaled so its
  // bit 0 is always zero.
  assign w_immI = {{52{i_mem_data[31]}}, i_mem_data[31:20]};
  assign w_immS = {{52{i_mem_data[31]}}, i_mem_data[31:25], i_mem_data[11:7]};
  assign w_immB = {{51{i_mem_data[31]}}, i_mem_data[31], i_mem_data[7],
                   i_mem_data[30:25], i_mem_data[11:8], 1'b0};

  polirv_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1Data),
    .o_rdata2 (w_rs2Data),
    .i_we     (w_regWe),
    .i_waddr  (w_rd),
    .i_wdata  (w_wbData)
  );

  // Decoder: picks the ALU operation and second operand and raises the
  // control strobes. Anything that does not match a supported encoding
  // exactly keeps the defaults, which is what makes it a NOP.
  always_comb begin
    w_aluOp       = ALU_ADD;
    w_opB         = w_rs2Data;
    w_regWe       = 1'b0;
    w_isLoad      = 1'b0;
    w_isStore     = 1'b0;
    w_branchTaken = 1'b0;
    case (w_opcode)
      OP_R: begin
        if (w_funct3 == F3_ADD_SUB && w_funct7 == F7_BASE) begin
          w_aluOp = ALU_ADD;
          w_regWe = 1'b1;
        end else if (w_funct3 == F3_ADD_SUB && w_funct7 == F7_SUB) begin
          w_aluOp = ALU_SUB;
          w_regWe = 1'b1;
        end else if (w_funct3 == F3_AND && w_funct7 == F7_BASE) begin
          w_aluOp = ALU_AND;
          w_regWe = 1'b1;
        end else if (w_funct3 == F3_OR && w_funct7 == F7_BASE) begin
          w_aluOp = ALU_OR;
          w_regWe = 1'b1;
        end
      end
      OP_IMM: begin
        if (w_funct3 == F3_ADDI) begin
          w_opB   = w_immI;
          w_regWe = 1'b1;
        end
      end
      OP_LOAD: begin
        if (w_funct3 == F3_DOUBLE) begin
          w_opB    = w_immI;
          w_regWe  = 1'b1;
          w_isLoad = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_funct3 == F3_DOUBLE) begin
          w_opB     = w_immS;
          w_isStore = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (w_funct3 == F3_BEQ) begin
          w_branchTaken = (w_rs1Data == w_rs2Data);
        end else if (w_funct3 == F3_BNE) begin
          w_branchTaken = (w_rs1Data != w_rs2Data);
        end
      end
      default: begin
      end
    endcase
  end

  // The ALU also forms the load/store effective address, so one adder serves
  // arithmetic and memory addressing.
  assign w_aluResult = aluCompute(w_aluOp, w_rs1Data, w_opB);

  // Memory strobes are masked by reset so a store caught by a mid-run reset
  // never reaches memory and the bus is released.
  assign d_mem_we   = w_isStore & ~rst_n;
  assign d_mem_re   = w_isLoad & ~rst_n;
  assign d_mem_addr = (d_mem_we | d_mem_re) ? w_aluResult[DADDR_W+2:3] : '0;
  assign d_mem_data = d_mem_we ? w_rs2Data : 64'bz;

  assign w_wbData = w_isLoad ? d_mem_data : w_aluResult;
  assign w_nextPc = w_branchTaken ? (r_pc + w_immB) : (r_pc + 64'd4);

  // Program counter: reload on reset, otherwise advance by one instruction
  // or jump to the taken branch target.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_nextPc;
    end
  end

  assign i_mem_addr = r_pc[IADDR_W+1:2];

endmodule

// File: tb/tb_polirv_core.sv
// tb_polirv_core: scoreboard bench for polirv_core. Each test loads a small
// program, pushes the expected per-cycle fetch address and memory activity
// into a queue, and a negedge monitor pops and compares every cycle.
module tb_polirv_core;

  typedef struct packed {
    logic [5:0]  iaddr;
    logic        we;
    logic        re;
    logic        chkAddr;
    logic [5:0]  daddr;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic        d_mem_we;
  logic        d_mem_re;
  logic [5:0]  d_mem_addr;
  wire  [63:0] w_bus;

  logic [31:0] imem [64];
  logic [63:0] dmem [64];
  logic        presetEn;
  logic [5:0]  presetAddr;
  logic [63:0] presetVal;

  exp_t        expQ [$];
  exp_t        monE;
  int          checks;
  int          failures;

  polirv_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mem_addr (i_mem_addr),
    .i_mem_data (i_mem_data),
    .d_mem_we   (d_mem_we),
    .d_mem_re   (d_mem_re),
    .d_mem_addr (d_mem_addr),
    .d_mem_data (w_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational instruction fetch, data bus driven only on
  // reads, stores captured at the rising edge.
  assign i_mem_data = imem[i_mem_addr];
  assign w_bus      = d_mem_re ? dmem[d_mem_addr] : 64'bz;

  always @(posedge clk) begin
    if (d_mem_we) begin
      dmem[d_mem_addr] <= w_bus;
    end else if (presetEn) begin
      dmem[presetAddr] <= presetVal;
    end
  end

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic pushExp(input logic [5:0] ia, input logic we, input logic re,
                         input logic chkA, input logic [5:0] da, input logic [63:0] d);
    exp_t e;
    e.iaddr   = ia;
    e.we      = we;
    e.re      = re;
    e.chkAddr = chkA;
    e.daddr   = da;
    e.data    = d;
    expQ.push_back(e);
  endtask

  task automatic expNop(input logic [5:0] ia);
    pushExp(ia, 1'b0, 1'b0, 1'b1, 6'd0, 64'd0);
  endtask

  task automatic expRst(input logic [5:0] ia);
    pushExp(ia, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
  endtask

  task automatic expSt(input logic [5:0] ia, input logic [5:0] da, input logic [63:0] d);
    pushExp(ia, 1'b1, 1'b0, 1'b1, da, d);
  endtask

  task automatic expLd(input logic [5:0] ia, input logic [5:0] da);
    pushExp(ia, 1'b0, 1'b1, 1'b1, da, 64'd0);
  endtask

  task automatic checkOutput(input exp_t e);
    compareVal("iaddr", {58'd0, i_mem_addr}, {58'd0, e.iaddr});
    compareVal("we", {63'd0, d_mem_we}, {63'd0, e.we});
    compareVal("re", {63'd0, d_mem_re}, {63'd0, e.re});
    if (e.chkAddr) compareVal("daddr", {58'd0, d_mem_addr}, {58'd0, e.daddr});
    if (e.we) compareVal("wdata", w_bus, e.data);
  endtask

  // Monitor: one expected entry per cycle while the scoreboard holds any.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monE = expQ.pop_front();
      checkOutput(monE);
    end
  end

  task automatic waitDrain();
    int cyc = 0;
    while (expQ.size() != 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: actual=%0d entries left required=0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input int testId);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    if (testId == 3) begin
      presetEn   = 1'b1;
      presetAddr = 6'd4;
      presetVal  = 64'h1234;
    end
    case (testId)
      0: begin
        imem[0] = encI(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[1] = encI(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);
        imem[2] = encR(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
        imem[3] = encR(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4);
        imem[4] = encR(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5);
        imem[5] = encR(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd6);
        imem[6] = encS(12'd0, 5'd3, 5'd0);
        imem[7] = encS(12'd8, 5'd4, 5'd0);
        imem[8] = encS(12'd16, 5'd5, 5'd0);
        imem[9] = encS(12'd24, 5'd6, 5'd0);
      end
      1: begin
        imem[0] = encI(12'd42, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[1] = encS(12'd16, 5'd1, 5'd0);
        imem[2] = encI(12'd16, 5'd0, 3'b011, 5'd2, 7'b0000011);
        imem[3] = encS(12'd24, 5'd2, 5'd0);
        imem[4] = encS(12'd21, 5'd1, 5'd0);
      end
      2: begin
        imem[0] = encI(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[2] = encB(13'd8, 5'd0, 5'd0, 3'b000);
        imem[3] = encI(12'd99, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[4] = encB(13'd8, 5'd0, 5'd0, 3'b001);
        imem[5] = encI(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);
        imem[6] = 32'hFFFF_FFFF;
        imem[7] = encS(12'd0, 5'd1, 5'd0);
        imem[8] = encS(12'd8, 5'd0, 5'd0);
        imem[9] = encB(13'h1FDC, 5'd0, 5'd1, 3'b001);
      end
      default: begin
        imem[0] = encI(12'd42, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[1] = encS(12'd32, 5'd1, 5'd0);
      end
    endcase
    @(posedge clk);
    #1;
    presetEn = 1'b0;
    repeat (5) expRst(6'd0);
    case (testId)
      0: begin
        for (int i = 0; i < 6; i++) expNop(6'(i));
        expSt(6'd6, 6'd0, 64'd12);
        expSt(6'd7, 6'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        expSt(6'd8, 6'd2, 64'd5);
        expSt(6'd9, 6'd3, 64'd7);
        expNop(6'd10);
      end
      1: begin
        expNop(6'd0);
        expSt(6'd1, 6'd2, 64'd42);
        expLd(6'd2, 6'd2);
        expSt(6'd3, 6'd3, 64'd42);
        expSt(6'd4, 6'd2, 64'd42);
        expNop(6'd5);
      end
      2: begin
        expNop(6'd0);
        expNop(6'd1);
        expNop(6'd2);
        expNop(6'd4);
        expNop(6'd5);
        expNop(6'd6);
        expSt(6'd7, 6'd0, 64'd1);
        expSt(6'd8, 6'd1, 64'd0);
        expNop(6'd9);
        expNop(6'd0);
      end
      default: begin
        expNop(6'd0);
        expRst(6'd1);
        expRst(6'd0);
        expNop(6'd0);
        expSt(6'd1, 6'd4, 64'd42);
        expNop(6'd2);
      end
    endcase
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    if (testId == 3) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      compareVal("store_suppressed", dmem[4], 64'h1234);
    end
    waitDrain();
    if (testId == 3) compareVal("store_after_reset", dmem[4], 64'd42);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b1;
    presetEn   = 1'b0;
    presetAddr = 6'd0;
    presetVal  = 64'd0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    $display("[TB] arithmetic program");
    applyStimulus(0);
    $display("[TB] load/store program");
    applyStimulus(1);
    $display("[TB] branch, x0 and illegal encoding program");
    applyStimulus(2);
    $display("[TB] mid-run reset program");
    applyStimulus(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/polirv_core.md
Name: polirv_core

Overview:
- Single-cycle RISC-V RV64I-subset processor core.
- Fetches 32-bit instructions from an external instruction memory and accesses an external 64-bit data memory over a shared bidirectional data bus.
- Sits between the system clock/reset and the combined instruction/data memory block (memoria).
- Intended to run small preloaded test programs of up to 64 instructions.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IADDR_W, 6, instruction memory word-address width.
- DADDR_W, 6, data memory doubleword-address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-high (asserted when 1).
- i_mem_addr  output  6  instruction word address; equals PC[7:2].
- i_mem_data  input  32  instruction returned combinationally by memory.
- d_mem_we  output  1  data memory write enable.
- d_mem_re  output  1  data memory read enable.
- d_mem_addr  output  6  data doubleword address; equals effective address [8:3].
- d_mem_data  inout  64  shared data bus. Core drives it only while d_mem_we=1, otherwise high-Z. Memory drives it only while d_mem_re=1.

Behaviour:
- Reset (rst_n=1 at a rising edge):
  - PC is loaded with RESET_PC.
  - All 32 registers are cleared to 0.
  - While rst_n=1, d_mem_we=0 and d_mem_re=0, and the core releases the bus to high-Z.
- Execution:
  - One instruction completes per clock.
  - Decode, register read, ALU, memory access and writeback are combinational within the cycle.
  - PC and the register file update on the rising edge.
- Supported instructions:
  - ADD, SUB, AND, OR (opcode 0110011).
  - ADDI (0010011, funct3 000).
  - LD (0000011, funct3 011).
  - SD (0100011, funct3 011).
  - BEQ and BNE (1100011, funct3 000/001).
  - Any other encoding executes as a NOP: no register write, no memory access, PC+4.
- Immediates are sign-extended to 64 bits in the I, S and B formats. The B-format immediate is imm[12:1] with bit 0 = 0.
- Next PC:
  - PC+imm when the branch is taken; otherwise PC+4.
  - Arithmetic is 64-bit and wraps modulo 2^64.
  - Because i_mem_addr uses only PC[7:2], fetch wraps every 256 bytes.
- x0 reads as 0 and ignores writes. A write to rd is visible to the next instruction's read.
- LD:
  - d_mem_re=1 and d_mem_addr=(rs1+imm)[8:3].
  - The value sampled on d_mem_data is written to rd at the edge.
- SD:
  - d_mem_we=1, the core drives rs2 onto d_mem_data, and d_mem_addr=(rs1+imm)[8:3].
  - The memory captures the data at the rising edge.
- For non-memory instructions, d_mem_we=d_mem_re=0 and d_mem_addr=0.
- d_mem_we and d_mem_re are never both 1.
- Address bits [2:0] of the effective address are ignored; there is no misalignment trap.
- Reset asserted mid-program takes effect at the next edge and overrides any pending register or memory write from that cycle: the cycle's write is suppressed.

Decomposition:
- Shared package polirv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - funct3/funct7 constants;
  - ALU operation enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR).
- One sub-module is natural: polirv_regfile, 32x64 registers with two combinational read ports, one synchronous write port, x0 hardwired to 0, and synchronous clear on rst_n.
- Decoder, immediate generator and ALU stay inside polirv_core.

Test Plan:
- Reset:
  - Hold rst_n=1 for 5 cycles.
  - Required: i_mem_addr=0, d_mem_we=0, d_mem_re=0 and the bus is high-Z throughout.
  - After releasing reset, i_mem_addr steps 0,1,2,… one per cycle.
- Arithmetic:
  - Program: ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; SUB x4,x1,x2; AND x5,x1,x2; OR x6,x1,x2.
  - Required: x3=12, x4=0xFFFFFFFFFFFFFFFE, x5=5, x6=7.
- Memory:
  - Program: ADDI x1,x0,42; SD x1,16(x0); LD x2,16(x0).
  - Required: during SD, d_mem_we=1, d_mem_addr=2 and d_mem_data=42.
  - Required: during LD, d_mem_re=1 and d_mem_addr=2, and x2=42 afterwards.
- Branch:
  - Program: BEQ x0,x0,+8 placed at PC 8.
  - Required: the next i_mem_addr is 4 (PC 16) and the skipped instruction has no effect.
  - BNE x0,x0,+8 falls through to PC 12.
- x0 and illegal encodings:
  - ADDI x0,x0,9 leaves x0=0.
  - Instruction 0xFFFFFFFF behaves as a NOP: PC advances by 4 and there is no memory strobe.
- Mid-run reset:
  - Assert rst_n=1 during the SD cycle.
  - Required: no memory write occurs and PC returns to 0 at the next edge.
